axi4_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI4 master write port (AW, W, B) between NUM_REQ upstream write requesters, for example DMA engines or UVM-driven stubs.
- Sits between the requesters and the interconnect-facing AXI4 master interface.
- Serialises bursts: each granted burst gets an AW handshake, then its full W burst up to WLAST, before the next grant.
- Routes B responses back to their requester by prefixing the requester index onto AWID.

---
 rtl/axi4_wr_arbiter_if.sv | 76 +++++++
 rtl/axi4_wr_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_wr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_wr_arbiter_if.sv
// Bus bundle for axi4_wr_arbiter.
// Carries the NUM_REQ requester-side write channels (flattened, slice i = requester i)
// and the single interconnect-facing AXI4 write master port (AW, W, B).
//   modport master : arbiter view (accepts requester AW/W, drives master AW/W, routes B)
//   modport slave  : environment view (requesters plus downstream interconnect)
interface axi4_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_REQ)
);
    // Requester side
    logic [NUM_REQ*ADDR_WIDTH-1:0]   s_awaddr;
    logic [NUM_REQ*8-1:0]            s_awlen;
    logic [NUM_REQ*2-1:0]            s_awburst;
    logic [NUM_REQ*ID_WIDTH-1:0]     s_awid;
    logic [NUM_REQ-1:0]              s_awvalid;
    logic [NUM_REQ-1:0]              s_awready;
    logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] s_wstrb;
    logic [NUM_REQ-1:0]              s_wlast;
    logic [NUM_REQ-1:0]              s_wvalid;
    logic [NUM_REQ-1:0]              s_wready;
    logic [ID_WIDTH-1:0]             s_bid;
    logic [1:0]                      s_bresp;
    logic [NUM_REQ-1:0]              s_bvalid;
    logic [NUM_REQ-1:0]              s_bready;

    // Master side
    logic [ADDR_WIDTH-1:0]           M_AWADDR;
    logic [7:0]                      M_AWLEN;
    logic [1:0]                      M_AWBURST;
    logic [ID_WIDTH+IDX_W-1:0]       M_AWID;
    logic                            M_AWVALID;
    logic                            M_AWREADY;
    logic [DATA_WIDTH-1:0]           M_WDATA;
    logic [DATA_WIDTH/8-1:0]         M_WSTRB;
    logic                            M_WLAST;
    logic                            M_WVALID;
    logic                            M_WREADY;
    logic [ID_WIDTH+IDX_W-1:0]       M_BID;
    logic [1:0]                      M_BRESP;
    logic                            M_BVALID;
    logic                            M_BREADY;

    modport master (
        input  s_awaddr, s_awlen, s_awburst, s_awid, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        output M_AWADDR, M_AWLEN, M_AWBURST, M_AWID, M_AWVALID,
        input  M_AWREADY,
        output M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
        input  M_WREADY,
        input  M_BID, M_BRESP, M_BVALID,
        output M_BREADY
    );

    modport slave (
        output s_awaddr, s_awlen, s_awburst, s_awid, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        input  M_AWADDR, M_AWLEN, M_AWBURST, M_AWID, M_AWVALID,
        output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
        output M_WREADY,
        output M_BID, M_BRESP, M_BVALID,
        input  M_BREADY
    );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write master port between NUM_REQ requesters.
// A granted burst gets its AW handshake, then its whole W burst up to WLAST, before the
// next grant. The requester index is prefixed onto AWID so B responses route back.
// Ports:
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus           : axi4_wr_arbiter_if.master (requester AW/W/B + master AW/W/B)
//   grant_idx     : current or last granted requester
//   busy          : high whenever the FSM is not idle
//   len_err       : sticky WLAST/length disagreement (only with AXI_WR_ARB_LEN_CHECK_EN)
// Optional feature macro: AXI_WR_ARB_LEN_CHECK_EN -- beat counter drives M_WLAST from the
// registered AWLEN and flags requesters whose s_wlast disagrees.
module axi4_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi4_wr_arbiter_if.master    bus,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    ,
    output logic                 len_err
`endif
);

    localparam int unsigned MID_W = ID_WIDTH + IDX_W;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [7:0]              awlen_q, awlen_d;
    logic [1:0]              awburst_q, awburst_d;
    logic [MID_W-1:0]        awid_q, awid_d;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [7:0]              cnt_q, cnt_d;
    logic                    len_err_q, len_err_d;
`endif

    // Round-robin search: first set s_awvalid bit starting at rr_ptr, wrapping.
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_found && bus.s_awvalid[i] &&
                    ((32'(rr_ptr_q) + k) % NUM_REQ) == i) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Winner's AW fields.
    logic [ADDR_WIDTH-1:0]   win_awaddr;
    logic [7:0]              win_awlen;
    logic [1:0]              win_awburst;
    logic [ID_WIDTH-1:0]     win_awid;
    always_comb begin
        win_awaddr  = '0;
        win_awlen   = '0;
        win_awburst = '0;
        win_awid    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_awaddr  = bus.s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_awlen   = bus.s_awlen[i*8 +: 8];
                win_awburst = bus.s_awburst[i*2 +: 2];
                win_awid    = bus.s_awid[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    // Granted requester's W channel.
    logic                    sel_wvalid;
    logic                    sel_wlast;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_W-1:0]       sel_wstrb;
    always_comb begin
        sel_wvalid = 1'b0;
        sel_wlast  = 1'b0;
        sel_wdata  = '0;
        sel_wstrb  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_wvalid = bus.s_wvalid[i];
                sel_wlast  = bus.s_wlast[i];
                sel_wdata  = bus.s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb  = bus.s_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    logic w_last;
    logic w_hs;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    assign w_last = (cnt_q == 8'd0);
`else
    assign w_last = sel_wlast;
`endif
    assign w_hs = (state_q == StData) && sel_wvalid && bus.M_WREADY;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        awburst_d     = awburst_q;
        awid_d        = awid_q;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
        cnt_d         = cnt_q;
        len_err_d     = len_err_q;
`endif
        bus.s_awready = '0;
        bus.s_wready  = '0;
        bus.M_WVALID  = 1'b0;
        bus.M_WDATA   = '0;
        bus.M_WSTRB   = '0;
        bus.M_WLAST   = 1'b0;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    bus.s_awready = NUM_REQ'(1) << win_idx;
                    awaddr_d      = win_awaddr;
                    awlen_d       = win_awlen;
                    awburst_d     = win_awburst;
                    awid_d        = {win_idx, win_awid};
                    grant_d       = win_idx;
                    rr_ptr_d      = IDX_W'((32'(win_idx) + 1) % NUM_REQ);
                    awvalid_d     = 1'b1;
                    state_d       = StAddr;
                end
            end
            StAddr: begin
                if (bus.M_AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = StData;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
                    cnt_d     = awlen_q;
`endif
                end
            end
            StData: begin
                bus.M_WVALID = sel_wvalid;
                bus.M_WDATA  = sel_wdata;
                bus.M_WSTRB  = sel_wstrb;
                bus.M_WLAST  = w_last;
                bus.s_wready = NUM_REQ'(bus.M_WREADY) << grant_q;
                if (w_hs) begin
`ifdef AXI_WR_ARB_LEN_CHECK_EN
                    cnt_d = cnt_q - 8'd1;
                    if (sel_wlast != w_last) begin
                        len_err_d = 1'b1;
                    end
`endif
                    if (w_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
            awid_q    <= '0;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
            cnt_q     <= '0;
            len_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awburst_q <= awburst_d;
            awid_q    <= awid_d;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
`endif
        end
    end

    assign bus.M_AWVALID = awvalid_q;
    assign bus.M_AWADDR  = awaddr_q;
    assign bus.M_AWLEN   = awlen_q;
    assign bus.M_AWBURST = awburst_q;
    assign bus.M_AWID    = awid_q;
    assign grant_idx     = grant_q;
    assign busy          = (state_q != StIdle);
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    assign len_err       = len_err_q;
`endif

    // B routing: upper M_BID bits select the requester; out-of-range indices are sunk.
    logic [IDX_W:0] b_idx;
    assign b_idx = {1'b0, bus.M_BID[MID_W-1:ID_WIDTH]};
    always_comb begin
        bus.s_bvalid = '0;
        bus.M_BREADY = 1'b1;
        bus.s_bid    = bus.M_BID[ID_WIDTH-1:0];
        bus.s_bresp  = bus.M_BRESP;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (b_idx == (IDX_W+1)'(i)) begin
                bus.s_bvalid[i] = bus.M_BVALID;
                bus.M_BREADY    = bus.s_bready[i];
            end
        end
    end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed self-checking bench for axi4_wr_arbiter (NUM_REQ=2, 32-bit addr/data, 4-bit ID).
module tb_axi4_wr_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [0:0] grant_idx;
    logic       busy;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic       len_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axi4_wr_arbiter_if #(
        .NUM_REQ   (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4)
    ) bus ();

    axi4_wr_arbiter #(
        .NUM_REQ   (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .bus      (bus),
        .grant_idx(grant_idx),
        .busy     (busy)
`ifdef AXI_WR_ARB_LEN_CHECK_EN
        ,
        .len_err  (len_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_awaddr  = '0;
        bus.s_awlen   = '0;
        bus.s_awburst = '0;
        bus.s_awid    = '0;
        bus.s_awvalid = '0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wlast   = '0;
        bus.s_wvalid  = '0;
        bus.s_bready  = '0;
        bus.M_AWREADY = 1'b0;
        bus.M_WREADY  = 1'b0;
        bus.M_BID     = '0;
        bus.M_BRESP   = '0;
        bus.M_BVALID  = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        idle_inputs();
        step();
        step();
        ARESETn = 1'b1;
        settle();
    endtask

    task automatic set_aw(input int r, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id);
        bus.s_awaddr[r*32 +: 32] = addr;
        bus.s_awlen[r*8 +: 8]    = len;
        bus.s_awburst[r*2 +: 2]  = 2'b01;
        bus.s_awid[r*4 +: 4]     = id;
    endtask

    task automatic set_w(input int r, input logic [31:0] data, input logic last,
                         input logic valid);
        bus.s_wvalid[r]         = valid;
        bus.s_wdata[r*32 +: 32] = data;
        bus.s_wstrb[r*4 +: 4]   = 4'hF;
        bus.s_wlast[r]          = last;
    endtask

    // Full burst for requester g; entered in IDLE with g's AW request already driven.
    task automatic burst(input int g, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id);
        logic [31:0] d;
        settle();
        check_eq("idle_awready", 64'(bus.s_awready), 64'(1 << g));
        check_eq("idle_m_awvalid", 64'(bus.M_AWVALID), 64'd0);
        bus.M_AWREADY = 1'b1;
        step();
        bus.s_awvalid[g] = 1'b0;
        // Early W data must be ignored while still in ADDR
        set_w(g, 32'hEEEE_0000, 1'b0, 1'b1);
        settle();
        check_eq("addr_m_awvalid", 64'(bus.M_AWVALID), 64'd1);
        check_eq("addr_m_awaddr", 64'(bus.M_AWADDR), 64'(addr));
        check_eq("addr_m_awlen", 64'(bus.M_AWLEN), 64'(len));
        check_eq("addr_m_awid", 64'(bus.M_AWID), 64'((g << 4) | int'(id)));
        check_eq("addr_grant_idx", 64'(grant_idx), 64'(g));
        check_eq("addr_busy", 64'(busy), 64'd1);
        check_eq("addr_awready", 64'(bus.s_awready), 64'd0);
        check_eq("addr_wready", 64'(bus.s_wready), 64'd0);
        check_eq("addr_m_wvalid", 64'(bus.M_WVALID), 64'd0);
        step();
        check_eq("data_m_awvalid", 64'(bus.M_AWVALID), 64'd0);
        for (int b = 0; b <= int'(len); b++) begin
            d = 32'hA000_0000 | 32'(g << 8) | 32'(b);
            set_w(g, d, (b == int'(len)), 1'b1);
            bus.M_WREADY = 1'b1;
            settle();
            check_eq("beat_m_wvalid", 64'(bus.M_WVALID), 64'd1);
            check_eq("beat_m_wdata", 64'(bus.M_WDATA), 64'(d));
            check_eq("beat_m_wlast", 64'(bus.M_WLAST), 64'(b == int'(len)));
            check_eq("beat_wready", 64'(bus.s_wready), 64'(1 << g));
            step();
        end
        set_w(g, 32'h0, 1'b0, 1'b0);
        bus.M_WREADY = 1'b0;
        settle();
        check_eq("post_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int hs_cnt;

        // Reset state
        ARESETn = 1'b0;
        idle_inputs();
        #3;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_m_awvalid", 64'(bus.M_AWVALID), 64'd0);
        check_eq("rst_m_wvalid", 64'(bus.M_WVALID), 64'd0);
        check_eq("rst_awready", 64'(bus.s_awready), 64'd0);
        check_eq("rst_wready", 64'(bus.s_wready), 64'd0);
        check_eq("rst_grant_idx", 64'(grant_idx), 64'd0);
        check_eq("rst_m_awaddr", 64'(bus.M_AWADDR), 64'd0);
        do_reset();

        // W data before any grant is ignored
        set_w(0, 32'h1234_5678, 1'b1, 1'b1);
        settle();
        check_eq("pregrant_wready", 64'(bus.s_wready), 64'd0);
        check_eq("pregrant_m_wvalid", 64'(bus.M_WVALID), 64'd0);
        set_w(0, 32'h0, 1'b0, 1'b0);

        // Single request: req0, addr 0x1000, len 3
        set_aw(0, 32'h1000, 8'd3, 4'h5);
        bus.s_awvalid = 2'b01;
        burst(0, 32'h1000, 8'd3, 4'h5);

        // Contention from reset: 0,1,0,1
        do_reset();
        set_aw(0, 32'h0100, 8'd1, 4'h3);
        set_aw(1, 32'h0200, 8'd1, 4'hC);
        for (int n = 0; n < 4; n++) begin
            bus.s_awvalid = 2'b11;
            if (n % 2 == 0) burst(0, 32'h0100, 8'd1, 4'h3);
            else            burst(1, 32'h0200, 8'd1, 4'hC);
        end

        // Backpressure: AW held 5 cycles, then W ready toggling
        do_reset();
        set_aw(0, 32'h3000, 8'd2, 4'h7);
        bus.s_awvalid = 2'b01;
        settle();
        check_eq("bp_awready", 64'(bus.s_awready), 64'd1);
        step();
        bus.s_awvalid[0] = 1'b0;
        set_aw(0, 32'hDEAD_BEEF, 8'hFF, 4'h1);
        set_aw(1, 32'h4000, 8'd0, 4'h2);
        bus.s_awvalid[1] = 1'b1;
        set_w(1, 32'h55, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            settle();
            check_eq("bp_m_awvalid", 64'(bus.M_AWVALID), 64'd1);
            check_eq("bp_m_awaddr", 64'(bus.M_AWADDR), 64'h3000);
            check_eq("bp_m_awlen", 64'(bus.M_AWLEN), 64'd2);
            check_eq("bp_m_awid", 64'(bus.M_AWID), 64'h07);
            check_eq("bp_wready_hold", 64'(bus.s_wready), 64'd0);
            step();
        end
        bus.M_AWREADY = 1'b1;
        step();
        bus.M_AWREADY = 1'b0;
        beat   = 0;
        hs_cnt = 0;
        for (int c = 0; c < 20 && beat < 3; c++) begin
            bus.M_WREADY = (c % 2 == 1);
            set_w(0, 32'hB0 + 32'(beat), (beat == 2), 1'b1);
            settle();
            check_eq("bp_m_wdata", 64'(bus.M_WDATA), 64'(32'hB0 + 32'(beat)));
            check_eq("bp_wready0", 64'(bus.s_wready[0]), 64'(c % 2));
            check_eq("bp_wready1", 64'(bus.s_wready[1]), 64'd0);
            if (bus.M_WVALID && bus.M_WREADY) hs_cnt++;
            if (bus.s_wready[0]) beat++;
            step();
        end
        set_w(0, 32'h0, 1'b0, 1'b0);
        bus.M_WREADY = 1'b0;
        settle();
        check_eq("bp_beats", 64'(hs_cnt), 64'd3);
        check_eq("bp_busy_after", 64'(busy), 64'd0);
        check_eq("bp_next_grant", 64'(bus.s_awready), 64'b10);
        bus.s_awvalid = 2'b00;
        set_w(1, 32'h0, 1'b0, 1'b0);

        // B routing
        bus.M_BID    = 5'h1A;
        bus.M_BRESP  = 2'b10;
        bus.M_BVALID = 1'b1;
        bus.s_bready = 2'b10;
        settle();
        check_eq("b_bvalid", 64'(bus.s_bvalid), 64'b10);
        check_eq("b_bid", 64'(bus.s_bid), 64'hA);
        check_eq("b_bresp", 64'(bus.s_bresp), 64'b10);
        check_eq("b_m_bready", 64'(bus.M_BREADY), 64'd1);
        bus.s_bready = 2'b01;
        settle();
        check_eq("b_m_bready_low", 64'(bus.M_BREADY), 64'd0);
        bus.M_BID = 5'h07;
        settle();
        check_eq("b0_bvalid", 64'(bus.s_bvalid), 64'b01);
        check_eq("b0_bid", 64'(bus.s_bid), 64'h7);
        check_eq("b0_m_bready", 64'(bus.M_BREADY), 64'd1);
        bus.M_BVALID = 1'b0;
        settle();
        check_eq("b_idle_bvalid", 64'(bus.s_bvalid), 64'd0);
        bus.s_bready = 2'b00;

        // Reset mid-DATA after 2 of 4 beats
        do_reset();
        set_aw(0, 32'h5000, 8'd3, 4'h1);
        bus.s_awvalid = 2'b01;
        bus.M_AWREADY = 1'b1;
        step();
        bus.s_awvalid = 2'b00;
        step();
        bus.M_WREADY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            set_w(0, 32'hC0 + 32'(b), 1'b0, 1'b1);
            step();
        end
        set_w(0, 32'hC2, 1'b0, 1'b1);
        settle();
        check_eq("mid_m_wvalid_pre", 64'(bus.M_WVALID), 64'd1);
        ARESETn = 1'b0;
        #1;
        check_eq("mid_m_wvalid", 64'(bus.M_WVALID), 64'd0);
        check_eq("mid_wready", 64'(bus.s_wready), 64'd0);
        check_eq("mid_m_awvalid", 64'(bus.M_AWVALID), 64'd0);
        check_eq("mid_busy", 64'(busy), 64'd0);
        check_eq("mid_m_awaddr", 64'(bus.M_AWADDR), 64'd0);
        idle_inputs();
        step();
        ARESETn = 1'b1;
        set_aw(0, 32'h6000, 8'd0, 4'h2);
        set_aw(1, 32'h7000, 8'd0, 4'h3);
        bus.s_awvalid = 2'b11;
        settle();
        check_eq("mid_next_grant", 64'(bus.s_awready), 64'b01);
        bus.s_awvalid = 2'b00;

`ifdef AXI_WR_ARB_LEN_CHECK_EN
        // Early s_wlast on a 2-beat burst
        do_reset();
        check_eq("len_err_rst", 64'(len_err), 64'd0);
        set_aw(0, 32'h8000, 8'd1, 4'h4);
        bus.s_awvalid = 2'b01;
        bus.M_AWREADY = 1'b1;
        step();
        bus.s_awvalid = 2'b00;
        step();
        bus.M_WREADY = 1'b1;
        set_w(0, 32'hD0, 1'b1, 1'b1);
        settle();
        check_eq("lc_wlast_b0", 64'(bus.M_WLAST), 64'd0);
        step();
        check_eq("lc_len_err", 64'(len_err), 64'd1);
        check_eq("lc_busy_b1", 64'(busy), 64'd1);
        set_w(0, 32'hD1, 1'b0, 1'b1);
        settle();
        check_eq("lc_wlast_b1", 64'(bus.M_WLAST), 64'd1);
        step();
        set_w(0, 32'h0, 1'b0, 1'b0);
        bus.M_WREADY = 1'b0;
        settle();
        check_eq("lc_busy_end", 64'(busy), 64'd0);
        check_eq("lc_len_err_sticky", 64'(len_err), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
